// File: rtl/s2p_pkg.sv
// Shared types and sizing helpers for the serial2parallel deserializer.
// With S2P_PARITY_EN defined, each frame carries one trailing even-parity bit.
package s2p_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } s2p_state_e;

`ifdef S2P_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // Counter must hold 0..frame length so the last bit can be recognised.
    function automatic int s2p_cnt_w(input int width);
        return $clog2(width + PAR_BITS + 1);
    endfunction

endpackage

// File: rtl/s2p_out_reg.sv
// Holding register for assembled words: valid/ready handshake and overrun detect.
module s2p_out_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             q_rdy,
    output logic [WIDTH-1:0] q,
    output logic             q_vld,
    output logic             drop
);

    logic take;

    // A slot frees up in the same cycle the consumer accepts, allowing back-to-back loads.
    assign take = load && (!q_vld || q_rdy);
    assign drop = load && q_vld && !q_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            q_vld <= 1'b0;
        end else if (take) begin
            q     <= din;
            q_vld <= 1'b1;
        end else if (q_vld && q_rdy) begin
            q_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/serial2parallel.sv
// Serial-to-parallel deserializer: LSB-first bit collection, registered word output.
// Optional S2P_PARITY_EN adds a trailing even-parity bit per frame and a sticky perr flag.
module serial2parallel
    import s2p_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             si_vld,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             q_vld,
    input  logic             q_rdy,
    output logic             ovr,
`ifdef S2P_PARITY_EN
    output logic             perr,
`endif
    output logic             busy
);

    localparam int FRAME = WIDTH + PAR_BITS;
    localparam int CW    = s2p_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    s2p_state_e       state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sh;
    logic             shift_en;
    logic             load;
    logic             drop;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift_en  = 1'b0;
        if (clr) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: if (si_vld) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = CW'(1);
                    shift_en  = 1'b1;
                end
                SHIFT: if (si_vld) begin
                    // Parity bit sits at position WIDTH and never enters sh.
                    shift_en = (cnt < CW'(WIDTH));
                    if (cnt == LAST) begin
                        state_nxt = DONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                DONE: begin
                    state_nxt = si_vld ? SHIFT : IDLE;
                    cnt_nxt   = si_vld ? CW'(1) : '0;
                    shift_en  = si_vld;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef S2P_PARITY_EN
    logic par_q;
    logic par_bad;

    assign par_bad = ^{par_q, sh};
    assign load    = (state == DONE) && !clr && !par_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
            perr  <= 1'b0;
        end else begin
            if (!clr && si_vld && state == SHIFT && cnt == CW'(WIDTH))
                par_q <= si;
            if (clr)
                perr <= 1'b0;
            else if (state == DONE && par_bad)
                perr <= 1'b1;
        end
    end
`else
    assign load = (state == DONE) && !clr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
            busy  <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= (cnt_nxt != '0);
            if (clr)
                sh <= '0;
            else if (shift_en)
                sh <= {si, sh[WIDTH-1:1]};
            if (clr)
                ovr <= 1'b0;
            else if (drop)
                ovr <= 1'b1;
        end
    end

    // sh is sampled here before any shift on the same edge, so a bit arriving in DONE is kept.
    s2p_out_reg #(.WIDTH(WIDTH)) u_out (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .din   (sh),
        .q_rdy (q_rdy),
        .q     (q),
        .q_vld (q_vld),
        .drop  (drop)
    );

endmodule

// File: tb/tb_serial2parallel.sv
// Self-checking bench for serial2parallel: scoreboard of expected words plus directed checks.
module tb_serial2parallel;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             si = 1'b0;
    logic             si_vld = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] q;
    logic             q_vld;
    logic             q_rdy;
    logic             ovr;
    logic             busy;
    logic             rdy_reg = 1'b1;
    logic             rdy_follow = 1'b0;
`ifdef S2P_PARITY_EN
    logic             perr;
`endif

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] sb[$];

    assign q_rdy = rdy_follow ? q_vld : rdy_reg;

    always #5 clk = ~clk;

    serial2parallel #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .si     (si),
        .si_vld (si_vld),
        .clr    (clr),
        .q      (q),
        .q_vld  (q_vld),
        .q_rdy  (q_rdy),
        .ovr    (ovr),
`ifdef S2P_PARITY_EN
        .perr   (perr),
`endif
        .busy   (busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        si     = b;
        si_vld = 1'b1;
        tick();
        si_vld = 1'b0;
    endtask

    // Sends WIDTH data bits LSB first (plus parity when enabled), with idle gaps between bits.
    task automatic send_frame(input logic [WIDTH-1:0] d, input logic p, input bit push, input int gap);
        for (int i = 0; i < WIDTH; i++) begin
            send_bit(d[i]);
`ifdef S2P_PARITY_EN
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("busy_gap", 32'(busy), 32'd1);
            end
`else
            for (int g = 0; g < gap && i < WIDTH - 1; g++) begin
                tick();
                chk("busy_gap", 32'(busy), 32'd1);
            end
`endif
        end
`ifdef S2P_PARITY_EN
        send_bit(p);
`else
        if (p) begin end
`endif
        if (push) sb.push_back(d);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d, input bit push, input int gap);
        send_frame(d, ^d, push, gap);
    endtask

    // Scoreboard consumer: every accepted word must match the oldest expected one.
    initial begin
        logic [WIDTH-1:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && q_vld && q_rdy) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", 32'(sb.size()), 32'd1);
                end else begin
                    exp = sb.pop_front();
                    chk("sb_word", 32'(q), 32'(exp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_qvld", 32'(q_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic: one-cycle q_vld, one clk after the DONE edge
        rdy_reg = 1'b1;
        send_word(4'hD, 1'b1, 0);
        chk("basic_vld_early", 32'(q_vld), 32'd0);
        tick();
        chk("basic_vld", 32'(q_vld), 32'd1);
        chk("basic_q", 32'(q), 32'hD);
        tick();
        chk("basic_vld_drop", 32'(q_vld), 32'd0);

        // Gapped input
        send_word(4'h6, 1'b1, 3);
        chk("gap_busy_end", 32'(busy), 32'd0);
        repeat (2) tick();
        chk("gap_q", 32'(q), 32'h6);
        chk("gap_ovr", 32'(ovr), 32'd0);

        // Overrun: second word dropped while first is held
        rdy_reg = 1'b0;
        send_word(4'hD, 1'b1, 0);
        send_word(4'h3, 1'b0, 0);
        tick();
        chk("ovr_q", 32'(q), 32'hD);
        chk("ovr_qvld", 32'(q_vld), 32'd1);
        chk("ovr_flag", 32'(ovr), 32'd1);
        rdy_reg = 1'b1;
        tick();
        chk("ovr_qvld_acc", 32'(q_vld), 32'd0);
        chk("ovr_sticky", 32'(ovr), 32'd1);

        // clr mid-word discards partial bits and the bit presented with it
        send_bit(1'b1);
        send_bit(1'b1);
        clr = 1'b1; si = 1'b1; si_vld = 1'b1;
        tick();
        clr = 1'b0; si_vld = 1'b0;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_ovr", 32'(ovr), 32'd0);
        send_word(4'h4, 1'b1, 0);
        repeat (2) tick();
        chk("clr_q", 32'(q), 32'h4);

        // Back-to-back continuous stream, consumer follows q_vld
        rdy_follow = 1'b1;
        send_word(4'hA, 1'b1, 0);
        send_word(4'h5, 1'b1, 0);
        send_word(4'hC, 1'b1, 0);
        repeat (3) tick();
        chk("b2b_ovr", 32'(ovr), 32'd0);
        chk("b2b_drain", 32'(sb.size()), 32'd0);
        rdy_follow = 1'b0;

`ifdef S2P_PARITY_EN
        send_frame(4'hD, ~^4'hD, 1'b0, 0);
        repeat (3) tick();
        chk("par_perr", 32'(perr), 32'd1);
        chk("par_novld", 32'(q_vld), 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("par_clr", 32'(perr), 32'd0);
        send_frame(4'hD, ^4'hD, 1'b1, 0);
        repeat (2) tick();
        chk("par_ok_q", 32'(q), 32'hD);
        chk("par_ok_perr", 32'(perr), 32'd0);
`endif

        // Async reset mid-frame
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_q", 32'(q), 32'd0);
        chk("arst_qvld", 32'(q_vld), 32'd0);
        chk("arst_ovr", 32'(ovr), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        send_word(4'hF, 1'b1, 0);
        repeat (2) tick();
        chk("arst_q_after", 32'(q), 32'hF);
        repeat (2) tick();
        chk("final_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
